instr_cache_core_dp: RTL and testbench

- Direct-mapped instruction-cache storage and lookup core with two read ports, sitting under the I$ controller.
- Each cycle it looks up two consecutive instruction words combinationally: word at `address` and word at `address+4`. This feeds a dual-issue fetch stage.
- The controller counts the miss penalty and pulses `bwrite` to refill a line from `block_in`.
- A word/half/byte store path exists. The I$ controller ties it off (`dwrite=0`).

---
 rtl/icache_pkg.sv | 29 ++
 rtl/icache_lookup.sv | 40 ++++
 rtl/instr_cache_core_dp.sv | 138 +++++++++++++
 tb/tb_instr_cache_core_dp.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared widths, store-mode encodings and byte-enable helper for the instruction cache core.
package icache_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int OFST_W     = 5;
    localparam int INDX_W     = 10;
    localparam int TAG_W      = ADDR_W - OFST_W - INDX_W;
    localparam int WORD_SEL_W = OFST_W - 2;
    localparam int LINES      = 1 << INDX_W;
    localparam int BLCK_W     = 8 << OFST_W;

    localparam logic [1:0] WM_WORD = 2'b00;
    localparam logic [1:0] WM_HALF = 2'b01;
    localparam logic [1:0] WM_BYTE = 2'b10;

    // Little-endian byte lanes; mode 11 yields an empty mask, so the store becomes a no-op.
    function automatic logic [3:0] store_be(input logic [1:0] mode, input logic [1:0] lane);
        logic [3:0] be;
        case (mode)
            WM_WORD: be = 4'b1111;
            WM_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            WM_BYTE: be = 4'b0001 << lane;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/icache_lookup.sv
// One combinational lookup port: tag compare against the indexed line and word selection.
module icache_lookup
    import icache_pkg::*;
#(
    parameter int ADDR_P = ADDR_W,
    parameter int DATA_P = DATA_W,
    parameter int OFST_P = OFST_W,
    parameter int INDX_P = INDX_W,
    parameter int TAG_P  = TAG_W,
    parameter int WSEL_P = WORD_SEL_W
) (
    input  logic [ADDR_P-1:0]          i_addr,
    input  logic                       i_dread,
    input  logic                       i_valid,
    input  logic [TAG_P-1:0]           i_tag,
    input  logic [(8<<OFST_P)-1:0]     i_line,
    output logic                       o_match,
    output logic                       o_hit,
    output logic [DATA_P-1:0]          o_word
);

    localparam int WORDS = 1 << WSEL_P;

    logic [DATA_P-1:0] w_words [WORDS];
    logic [WSEL_P-1:0] w_sel;

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_words
            assign w_words[gi] = i_line[gi*DATA_P +: DATA_P];
        end
    endgenerate

    assign w_sel   = i_addr[OFST_P-1:2];
    // o_match ignores dread so refill/store targeting does not depend on the read strobe.
    assign o_match = i_valid & (i_tag == i_addr[ADDR_P-1:OFST_P+INDX_P]);
    assign o_hit   = i_dread & o_match;
    assign o_word  = o_hit ? w_words[w_sel] : '0;

endmodule

// File: rtl/instr_cache_core_dp.sv
// Direct-mapped dual-read-port I$ storage core: lookups at address and address+4, refill and store paths.
// Optional refill/store tracing is compiled in with the ICACHE_TRACE_EN macro.
module instr_cache_core_dp
    import icache_pkg::*;
#(
    parameter int data = DATA_W,
    parameter int addr = ADDR_W,
    parameter int ofst = OFST_W,
    parameter int indx = INDX_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     SYS,
    input  logic                     dread,
    input  logic                     dwrite,
    input  logic [1:0]               dwmode,
    input  logic                     bread,
    input  logic                     bwrite,
    input  logic [addr-1:0]          address,
    input  logic [data-1:0]          data_in,
    input  logic [(8<<ofst)-1:0]     block_in,
    output logic [(8<<ofst)-1:0]     block_out,
    output logic [data-1:0]          data_out1,
    output logic [data-1:0]          data_out2,
    output logic                     hit1,
    output logic                     hit2
);

    localparam int TW = addr - ofst - indx;
    localparam int BW = 8 << ofst;
    localparam int WS = ofst - 2;
    localparam int NL = 1 << indx;

    logic [NL-1:0] r_valid;
    logic [TW-1:0] r_tag  [NL];
    logic [BW-1:0] r_line [NL];

    logic [addr-1:0] w_a2;
    logic [indx-1:0] w_idx1, w_idx2, w_fill_idx;
    logic [TW-1:0]   w_tag1, w_tag2, w_fill_tag;
    logic [WS-1:0]   w_wsel;
    logic            w_match1, w_match2;
    logic            w_fill_en, w_store_en;
    logic [3:0]      w_be;
    logic [31:0]     w_lane_data;
    logic [BW-1:0]   w_store_line;

    assign w_a2   = address + addr'(4);
    assign w_idx1 = address[ofst+indx-1:ofst];
    assign w_idx2 = w_a2[ofst+indx-1:ofst];
    assign w_tag1 = address[addr-1:ofst+indx];
    assign w_tag2 = w_a2[addr-1:ofst+indx];
    assign w_wsel = address[ofst-1:2];

    icache_lookup #(
        .ADDR_P(addr), .DATA_P(data), .OFST_P(ofst), .INDX_P(indx), .TAG_P(TW), .WSEL_P(WS)
    ) u_port1 (
        .i_addr  (address),
        .i_dread (dread),
        .i_valid (r_valid[w_idx1]),
        .i_tag   (r_tag[w_idx1]),
        .i_line  (r_line[w_idx1]),
        .o_match (w_match1),
        .o_hit   (hit1),
        .o_word  (data_out1)
    );

    icache_lookup #(
        .ADDR_P(addr), .DATA_P(data), .OFST_P(ofst), .INDX_P(indx), .TAG_P(TW), .WSEL_P(WS)
    ) u_port2 (
        .i_addr  (w_a2),
        .i_dread (dread),
        .i_valid (r_valid[w_idx2]),
        .i_tag   (r_tag[w_idx2]),
        .i_line  (r_line[w_idx2]),
        .o_match (w_match2),
        .o_hit   (hit2),
        .o_word  (data_out2)
    );

    assign block_out = bread ? r_line[w_idx1] : '0;

    // Port 1 has fill priority; a double miss needs a second refill strobe for port 2.
    assign w_fill_en  = bwrite & ~SYS & RESET & (~w_match1 | ~w_match2);
    assign w_fill_idx = w_match1 ? w_idx2 : w_idx1;
    assign w_fill_tag = w_match1 ? w_tag2 : w_tag1;

    assign w_be       = store_be(dwmode, address[1:0]);
    assign w_store_en = dwrite & ~bwrite & ~SYS & RESET & w_match1 & (|w_be);

    always_comb begin
        case (dwmode)
            WM_HALF: w_lane_data = {2{data_in[15:0]}};
            WM_BYTE: w_lane_data = {4{data_in[7:0]}};
            default: w_lane_data = data_in[31:0];
        endcase
    end

    always_comb begin
        w_store_line = r_line[w_idx1];
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
                w_store_line[int'(w_wsel)*data + b*8 +: 8] = w_lane_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_valid <= '0;
        end else if (w_fill_en) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_fill_en) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_line[w_fill_idx] <= block_in;
        end else if (w_store_en) begin
            r_line[w_idx1] <= w_store_line;
        end
    end

`ifdef ICACHE_TRACE_EN
    always_ff @(posedge CLK) begin
        if (w_fill_en) begin
            $display("icache refill index=%0h tag=%0h port=%0d", w_fill_idx, w_fill_tag, w_match1 ? 2 : 1);
        end
        if (w_store_en) begin
            $display("icache store address=%08h mode=%0d data=%08h", address, dwmode, data_in);
        end
    end
`else
    // Trace disabled: no simulation-only logic.
`endif

endmodule

// File: tb/tb_instr_cache_core_dp.sv
// Directed self-checking bench for instr_cache_core_dp with hand-computed expected values.
module tb_instr_cache_core_dp;

    logic         CLK = 1'b0;
    logic         RESET, SYS, dread, dwrite, bread, bwrite;
    logic [1:0]   dwmode;
    logic [31:0]  address, data_in;
    logic [255:0] block_in, block_out;
    logic [31:0]  data_out1, data_out2;
    logic         hit1, hit2;

    int checks   = 0;
    int failures = 0;

    instr_cache_core_dp dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SYS       (SYS),
        .dread     (dread),
        .dwrite    (dwrite),
        .dwmode    (dwmode),
        .bread     (bread),
        .bwrite    (bwrite),
        .address   (address),
        .data_in   (data_in),
        .block_in  (block_in),
        .block_out (block_out),
        .data_out1 (data_out1),
        .data_out2 (data_out2),
        .hit1      (hit1),
        .hit2      (hit2)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    function automatic logic [255:0] mk_block(input logic [31:0] base);
        logic [255:0] blk;
        for (int k = 0; k < 8; k++) blk[k*32 +: 32] = base + 32'(k);
        return blk;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic refill(input logic [31:0] a, input logic [31:0] base);
        address  = a;
        block_in = mk_block(base);
        bwrite   = 1'b1;
        tick();
        bwrite   = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] mode, input logic [31:0] d);
        address = a;
        dwmode  = mode;
        data_in = d;
        dwrite  = 1'b1;
        tick();
        dwrite  = 1'b0;
    endtask

    task automatic look(input logic [31:0] a);
        address = a;
        #1;
    endtask

    initial begin
        RESET = 1'b0; SYS = 1'b0; dread = 1'b1; dwrite = 1'b0; bread = 1'b0; bwrite = 1'b0;
        dwmode = 2'b00; address = '0; data_in = '0; block_in = '0;
        tick();
        tick();
        RESET = 1'b1;

        look(32'h0000_1000);
        check("reset_hit1", 256'(hit1), 256'(0));
        check("reset_hit2", 256'(hit2), 256'(0));
        check("reset_d1", 256'(data_out1), 256'(0));
        check("reset_d2", 256'(data_out2), 256'(0));

        refill(32'h0000_1000, 32'hA000_0000);
        look(32'h0000_1000);
        check("fill_hit1", 256'(hit1), 256'(1));
        check("fill_hit2", 256'(hit2), 256'(1));
        check("fill_d1", 256'(data_out1), 256'(32'hA000_0000));
        check("fill_d2", 256'(data_out2), 256'(32'hA000_0001));
        bread = 1'b1;
        #1;
        check("block_out", block_out, mk_block(32'hA000_0000));
        bread = 1'b0;
        #1;
        check("block_out_off", block_out, 256'(0));

        look(32'h0000_101C);
        check("cross_hit1", 256'(hit1), 256'(1));
        check("cross_d1", 256'(data_out1), 256'(32'hA000_0007));
        check("cross_hit2", 256'(hit2), 256'(0));
        check("cross_d2", 256'(data_out2), 256'(0));
        refill(32'h0000_101C, 32'hB000_0000);
        look(32'h0000_101C);
        check("cross_fill_hit1", 256'(hit1), 256'(1));
        check("cross_fill_hit2", 256'(hit2), 256'(1));
        check("cross_fill_d2", 256'(data_out2), 256'(32'hB000_0000));

        store(32'h0000_1005, 2'b10, 32'h0000_00FF);
        look(32'h0000_1004);
        check("store_byte", 256'(data_out1), 256'(32'hA000_FF01));
        store(32'h0000_1006, 2'b01, 32'h0000_1234);
        look(32'h0000_1004);
        check("store_half", 256'(data_out1), 256'(32'h1234_FF01));
        store(32'h0000_1008, 2'b00, 32'hDEAD_BEEF);
        look(32'h0000_1008);
        check("store_word", 256'(data_out1), 256'(32'hDEAD_BEEF));
        store(32'h0000_100C, 2'b11, 32'h5555_5555);
        look(32'h0000_100C);
        check("store_mode11", 256'(data_out1), 256'(32'hA000_0003));
        store(32'h0000_2000, 2'b00, 32'h7777_7777);
        look(32'h0000_2000);
        check("store_miss_hit1", 256'(hit1), 256'(0));

        // bwrite and dwrite together: port-2 line fills, port-1 store is dropped
        address  = 32'h0000_103C;
        block_in = mk_block(32'hC000_0000);
        dwmode   = 2'b00;
        data_in  = 32'h0000_0055;
        bwrite   = 1'b1;
        dwrite   = 1'b1;
        tick();
        bwrite   = 1'b0;
        dwrite   = 1'b0;
        look(32'h0000_103C);
        check("both_d1", 256'(data_out1), 256'(32'hB000_0007));
        check("both_hit2", 256'(hit2), 256'(1));
        check("both_d2", 256'(data_out2), 256'(32'hC000_0000));

        refill(32'h0000_9000, 32'hD000_0000);
        look(32'h0000_9000);
        check("conflict_new_hit", 256'(hit1), 256'(1));
        check("conflict_new_d1", 256'(data_out1), 256'(32'hD000_0000));
        look(32'h0000_1000);
        check("conflict_old_miss", 256'(hit1), 256'(0));

        refill(32'hFFFF_FFFC, 32'hE000_0000);
        look(32'hFFFF_FFFC);
        check("wrap_d1", 256'(data_out1), 256'(32'hE000_0007));
        check("wrap_hit2_before", 256'(hit2), 256'(0));
        refill(32'hFFFF_FFFC, 32'hF000_0000);
        look(32'hFFFF_FFFC);
        check("wrap_hit2", 256'(hit2), 256'(1));
        check("wrap_d2", 256'(data_out2), 256'(32'hF000_0000));

        SYS = 1'b1;
        refill(32'h0000_4000, 32'h1234_0000);
        store(32'h0000_9000, 2'b00, 32'h1111_1111);
        look(32'h0000_9000);
        check("sys_lookup_hit", 256'(hit1), 256'(1));
        check("sys_store_blocked", 256'(data_out1), 256'(32'hD000_0000));
        SYS = 1'b0;
        look(32'h0000_4000);
        check("sys_fill_blocked", 256'(hit1), 256'(0));

        dread = 1'b0;
        look(32'h0000_9000);
        check("dread0_hit1", 256'(hit1), 256'(0));
        check("dread0_d1", 256'(data_out1), 256'(0));
        dread = 1'b1;

        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        look(32'h0000_9000);
        check("rst_hit1", 256'(hit1), 256'(0));
        check("rst_hit2", 256'(hit2), 256'(0));
        check("rst_d1", 256'(data_out1), 256'(0));
        bread = 1'b1;
        #1;
        check("rst_stale_block", block_out, mk_block(32'hD000_0000));
        bread = 1'b0;

        RESET = 1'b0;
        refill(32'h0000_5000, 32'h2222_0000);
        RESET = 1'b1;
        look(32'h0000_5000);
        check("rst_mid_fill", 256'(hit1), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
